// File: rtl/vigna_coproc_dispatch.sv
// vigna_coproc_dispatch
//
// Core-side initiator for the vigna coprocessor port. The block accepts one
// decoded M-extension instruction, launches it on the coprocessor handshake,
// captures the result and hands it to the register file through a separate
// writeback handshake. Each transaction is bounded by a timeout. After an
// abort, the block waits for the stray late response before it accepts new
// work.
//
// Parameters
//   CP_ID    value driven on cp_id for every transaction
//   TIMEOUT  cycles cp_valid may stay high without cp_ready; 0 disables it
//   TMR_W    timeout counter width, 2**TMR_W must exceed TIMEOUT
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   req_valid/req_ready   instruction handshake from the core
//                         (req_ready is high exactly when idle)
//   req_func/rd/op1/op2   funct3, destination register, rs1 and rs2 values
//   cp_valid/cp_ready     coprocessor handshake; cp_ready is a one-cycle
//                         completion pulse
//   cp_func/id/op1/op2    latched request fields, stable for the whole
//                         transaction
//   cp_result             coprocessor result, valid while cp_ready=1
//   wb_valid/wb_ready     register-file writeback handshake
//   wb_rd/wb_data         writeback target and data (data is 0 on timeout)
//   busy                  block is not idle
//   err                   one-cycle pulse when a timeout aborts a transaction

module vigna_coproc_dispatch #(
   parameter logic [2:0] CP_ID   = 3'd0,
   parameter int         TIMEOUT = 64,
   parameter int         TMR_W   = 8
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_func,
   input  logic [4:0]  req_rd,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,

   output logic        cp_valid,
   input  logic        cp_ready,
   output logic [2:0]  cp_func,
   output logic [2:0]  cp_id,
   output logic [31:0] cp_op1,
   output logic [31:0] cp_op2,
   input  logic [31:0] cp_result,

   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,

   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WB    = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Last timer value before the abort fires. When the timeout is disabled,
   // the value is unused, so clamp it to avoid a negative cast.
   localparam bit               TMO_EN   = (TIMEOUT > 0);
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic             wb_hs;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign cp_id     = CP_ID;
   assign wb_hs     = wb_valid && wb_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         timer    <= '0;
         cp_valid <= 1'b0;
         wb_valid <= 1'b0;
         err      <= 1'b0;
         cp_func  <= '0;
         cp_op1   <= '0;
         cp_op2   <= '0;
         wb_rd    <= '0;
         wb_data  <= '0;
      end else begin
         err <= 1'b0;

         // A writeback that was queued by a timeout abort may complete while
         // the block is still draining. The handshake therefore retires
         // wb_valid regardless of the current state.
         if (wb_hs)
            wb_valid <= 1'b0;

         case (state)
            IDLE: begin
               // A cp_ready that arrives here is stale and is ignored.
               if (req_valid) begin
                  cp_func  <= req_func;
                  cp_op1   <= req_op1;
                  cp_op2   <= req_op2;
                  wb_rd    <= req_rd;
                  cp_valid <= 1'b1;
                  timer    <= '0;
                  state    <= WAIT;
               end
            end

            WAIT: begin
               // The operands stay frozen because the coprocessor resamples
               // them at completion. Completion wins over a timeout that
               // fires at the same edge.
               if (cp_ready) begin
                  cp_valid <= 1'b0;
                  if (wb_rd != 5'd0) begin
                     wb_data  <= cp_result;
                     wb_valid <= 1'b1;
                     state    <= WB;
                  end else begin
                     state    <= IDLE;
                  end
               end else if (TMO_EN && (timer == TMR_LAST)) begin
                  cp_valid <= 1'b0;
                  err      <= 1'b1;
                  if (wb_rd != 5'd0) begin
                     wb_data  <= '0;
                     wb_valid <= 1'b1;
                  end
                  state    <= DRAIN;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            WB: begin
               if (wb_hs)
                  state <= IDLE;
            end

            DRAIN: begin
               // The late response ends the drain. If the aborted writeback
               // is still pending and not handshaking, finish it in WB.
               if (cp_ready)
                  state <= (!wb_valid || wb_ready) ? IDLE : WB;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vigna_coproc_dispatch.sv
// Self-checking bench for vigna_coproc_dispatch.
// The bench drives directed scenarios and randomized transactions through a
// behavioural coprocessor responder with programmable latency. A
// transaction-level model predicts how long cp_valid stays high, whether a
// timeout occurs, and the writeback content and timing.

module tb_vigna_coproc_dispatch;

   localparam int TIMEOUT = 64;
   localparam int TMR_W   = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_func;
   logic [4:0]  req_rd;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic        cp_valid;
   logic        cp_ready;
   logic [2:0]  cp_func;
   logic [2:0]  cp_id;
   logic [31:0] cp_op1;
   logic [31:0] cp_op2;
   logic [31:0] cp_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy;
   logic        err;

   int n_chk   = 0;
   int n_err   = 0;
   int low_run = 0;

   always #5 clk = ~clk;

   vigna_coproc_dispatch #(
      .CP_ID   (3'd0),
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_func  (req_func),
      .req_rd    (req_rd),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .cp_valid  (cp_valid),
      .cp_ready  (cp_ready),
      .cp_func   (cp_func),
      .cp_id     (cp_id),
      .cp_op1    (cp_op1),
      .cp_op2    (cp_op2),
      .cp_result (cp_result),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .busy      (busy),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge. low_run counts
   // the consecutive cp_valid-low cycles before the current one.
   task automatic step();
      if (!cp_valid) low_run++;
      else           low_run = 0;
      @(posedge clk);
      #1;
   endtask

   // One complete transaction.
   //   lat      responder asserts cp_ready in cp_valid cycle lat+1
   //            (-1 means the responder never answers)
   //   wb_delay edges with wb_ready low before the writeback is accepted
   //   late_k   after a timeout, the edge index of the stray cp_ready
   //   gap1     the previous transaction ended so that this one follows
   //            after exactly one idle cp_valid cycle
   //   imm      returns 1 if the block is idle in the first cycle after
   //            the coprocessor handshake
   task automatic do_txn(input logic [2:0] func, input logic [4:0] rd,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input int lat, input logic [31:0] res,
                         input int wb_delay, input int late_k,
                         input bit gap1, output bit imm);
      bit          tmo, has_wb;
      int          exp_cycles, kw, kl, kmax, n, bad;
      logic [31:0] exp_data;

      // Model: the transaction is aborted if the answer would arrive after
      // TIMEOUT cycles of cp_valid. An answer in exactly cycle TIMEOUT still
      // completes normally.
      tmo        = (TIMEOUT != 0) && (lat < 0 || lat >= TIMEOUT);
      exp_cycles = tmo ? TIMEOUT : lat + 1;
      has_wb     = (rd != 5'd0);
      exp_data   = tmo ? 32'd0 : res;
      kw         = has_wb ? wb_delay : -1;
      kl         = tmo ? late_k : -1;
      // The block is idle after both the writeback and the drain finish.
      kmax       = (kw > kl) ? kw : kl;
      imm        = (kmax < 0);

      chk("req_ready_pre", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_func  = func;
      req_rd    = rd;
      req_op1   = op1;
      req_op2   = op2;
      step();
      req_valid = 1'b0;
      req_func  = 3'($urandom);
      req_rd    = 5'($urandom);
      req_op1   = $urandom;
      req_op2   = $urandom;
      if (gap1) chk("cp_valid_gap", low_run, 32'd1);

      n   = 0;
      bad = 0;
      while (cp_valid && n < 300) begin
         n++;
         if (cp_op1 !== op1 || cp_op2 !== op2 || cp_func !== func || cp_id !== 3'd0 ||
             wb_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || err !== 1'b0)
            bad++;
         cp_ready  = (lat >= 0) && (n == lat + 1);
         cp_result = cp_ready ? res : $urandom;
         step();
         cp_ready  = 1'b0;
      end
      chk("cp_valid_cycles", n, exp_cycles);
      chk("cp_hold_cycles_bad", bad, 32'd0);

      for (int k = 0; k <= kmax; k++) begin
         chk("err_post", {31'd0, err}, {31'd0, (k == 0) && tmo});
         chk("wb_valid_post", {31'd0, wb_valid}, {31'd0, has_wb && (k <= kw)});
         if (has_wb && k <= kw) begin
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
            chk("wb_data", wb_data, exp_data);
         end
         chk("req_ready_post", {31'd0, req_ready}, 32'd0);
         chk("cp_valid_post", {31'd0, cp_valid}, 32'd0);
         wb_ready  = (k >= wb_delay);
         cp_ready  = tmo && (k == kl);
         cp_result = $urandom;
         step();
         cp_ready  = 1'b0;
         wb_ready  = 1'b0;
      end
      chk("req_ready_end", {31'd0, req_ready}, 32'd1);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("wb_valid_end", {31'd0, wb_valid}, 32'd0);
      chk("err_end", {31'd0, err}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          imm;
      bit          prev_imm;
      logic [4:0]  r_rd;
      int          r_lat;
      int          sel;

      resetn    = 1'b0;
      req_valid = 1'b0;
      req_func  = 3'd5;
      req_rd    = 5'd3;
      req_op1   = 32'hdead_beef;
      req_op2   = 32'h1234_5678;
      cp_ready  = 1'b0;
      cp_result = 32'd0;
      wb_ready  = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cp_valid", {31'd0, cp_valid}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_cp_op1", cp_op1, 32'd0);
      chk("rst_cp_op2", cp_op2, 32'd0);
      chk("rst_cp_func", {29'd0, cp_func}, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      resetn = 1'b1;
      step();

      // A cp_ready while idle is ignored.
      cp_ready = 1'b1;
      step();
      cp_ready = 1'b0;
      chk("idle_ready_busy", {31'd0, busy}, 32'd0);
      chk("idle_ready_wb", {31'd0, wb_valid}, 32'd0);

      // 1: basic multiply-style transaction with latency 34.
      do_txn(3'b000, 5'd5, 32'd7, 32'd6, 34, 32'd42, 0, 0, 1'b0, imm);
      // 2: rd==0, then an immediate second request one cycle later.
      do_txn(3'b000, 5'd0, 32'd7, 32'd6, 34, 32'd42, 0, 0, 1'b0, imm);
      do_txn(3'b001, 5'd0, 32'd9, 32'd3, 3, 32'd27, 0, 0, imm, imm);
      do_txn(3'b010, 5'd8, 32'd1, 32'd2, 0, 32'h55aa_00ff, 0, 0, imm, imm);
      // 3: writeback stalled for 5 cycles.
      do_txn(3'b011, 5'd9, 32'd100, 32'd3, 2, 32'd33, 5, 0, 1'b0, imm);
      // 4: responder never answers; the late cp_ready arrives around cycle 100.
      do_txn(3'b100, 5'd12, 32'd50, 32'd0, -1, 32'd0, 0, 35, 1'b0, imm);
      // Timeout in which the late cp_ready arrives while the writeback is pending.
      do_txn(3'b101, 5'd13, 32'd5, 32'd5, -1, 32'd0, 4, 1, 1'b0, imm);
      // Timeout with rd==0: the block drains, but no writeback occurs.
      do_txn(3'b110, 5'd0, 32'd5, 32'd5, 80, 32'd0, 0, 2, 1'b0, imm);
      // 5: cp_ready at the same edge as the timeout.
      do_txn(3'b111, 5'd7, 32'd11, 32'd12, TIMEOUT - 1, 32'hcafe_f00d, 1, 0, 1'b0, imm);

      // 6: reset during WAIT.
      req_valid = 1'b1;
      req_func  = 3'd4;
      req_rd    = 5'd6;
      req_op1   = 32'd77;
      req_op2   = 32'd88;
      step();
      req_valid = 1'b0;
      repeat (3) step();
      chk("mid_cp_valid", {31'd0, cp_valid}, 32'd1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("rstw_cp_valid", {31'd0, cp_valid}, 32'd0);
      chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rstw_busy", {31'd0, busy}, 32'd0);
      chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rstw_err", {31'd0, err}, 32'd0);
      do_txn(3'b000, 5'd6, 32'd77, 32'd88, 5, 32'd6776, 0, 0, 1'b0, imm);

      // Randomized transactions.
      prev_imm = imm;
      for (int t = 0; t < 40; t++) begin
         r_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         sel  = $urandom_range(0, 9);
         if (sel < 6)       r_lat = $urandom_range(0, 20);
         else if (sel < 9)  r_lat = $urandom_range(TIMEOUT - 4, TIMEOUT + 6);
         else               r_lat = -1;
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) step();
            prev_imm = 1'b0;
         end
         do_txn(3'($urandom), r_rd, $urandom, $urandom, r_lat, $urandom,
                $urandom_range(0, 6), $urandom_range(0, 10), prev_imm, imm);
         prev_imm = imm;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
